// File: rtl/sram_bus_adapter.sv
// Bridges the CPU req/gnt + recv/ack bus onto a single-cycle SRAM/ROM macro,
// with a two-entry response path (s1 + hold) so the bus can stall responses.
module sram_bus_adapter #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          READ_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    output logic              bus_gnt,
    input  logic              bus_wen,
    input  logic [3:0]        bus_strb,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_recv,
    input  logic              bus_ack,
    output logic              bus_error,
    output logic [31:0]       bus_rdata,
    output logic              mem_cen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    logic        acc, hit, bad, ack;
    logic        s1_valid, s1_err, s1_held;
    logic [31:0] s1_data, s1_rd;
    logic        hold_valid, hold_err;
    logic [31:0] hold_data;
    logic        s1_stall;

    assign bus_gnt = !reset && !hold_valid;
    assign acc     = bus_req && bus_gnt;
    assign hit     = (bus_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign bad     = !hit || (READ_ONLY && bus_wen);

    assign mem_cen   = acc && !bad;
    assign mem_addr  = bus_addr[ADDR_W-1:0];
    assign mem_wdata = bus_wdata;
    assign mem_wstrb = (acc && !bad && bus_wen && !READ_ONLY) ? bus_strb : 4'b0000;

    // Once s1 has waited behind hold for a cycle, the macro output may have
    // moved on, so the word is frozen in s1_data.
    assign s1_rd = s1_held ? s1_data : (s1_err ? 32'h0 : mem_rdata);

    always_comb begin
        bus_recv  = 1'b0;
        bus_error = 1'b0;
        bus_rdata = 32'h0;
        if (!reset) begin
            bus_recv = hold_valid || s1_valid;
            if (hold_valid) begin
                bus_error = hold_err;
                bus_rdata = hold_data;
            end else if (s1_valid) begin
                bus_error = s1_err;
                bus_rdata = s1_rd;
            end
        end
    end

    assign ack      = bus_recv && bus_ack;
    // s1 cannot advance while hold is occupied and not being consumed.
    assign s1_stall = s1_valid && hold_valid && !ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_held  <= 1'b0;
            s1_data  <= 32'h0;
        end else if (s1_stall) begin
            s1_held <= 1'b1;
            s1_data <= s1_rd;
        end else begin
            s1_valid <= acc;
            s1_err   <= bad;
            s1_held  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_err   <= 1'b0;
            hold_data  <= 32'h0;
        end else if (hold_valid && ack) begin
            if (s1_valid) begin
                hold_data <= s1_rd;
                hold_err  <= s1_err;
            end else begin
                hold_valid <= 1'b0;
            end
        end else if (!hold_valid && s1_valid && !ack) begin
            hold_valid <= 1'b1;
            hold_data  <= s1_rd;
            hold_err   <= s1_err;
        end
    end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Directed bench for sram_bus_adapter with a ROM model whose word at byte
// address a is 32'h1000_0000 | a, returned the cycle after mem_cen.
module tb_sram_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req, bus_gnt, bus_wen;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_recv, bus_ack, bus_error;
    logic [31:0] bus_rdata;
    logic        mem_cen;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bus_adapter dut (
        .clk(clk), .reset(reset),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_wen(bus_wen),
        .bus_strb(bus_strb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_recv(bus_recv), .bus_ack(bus_ack), .bus_error(bus_error),
        .bus_rdata(bus_rdata),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always @(posedge clk)
        if (mem_cen) mem_rdata <= 32'h1000_0000 | {20'h0, mem_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic wen, input logic [31:0] addr, input logic ack);
        bus_req  = req;
        bus_wen  = wen;
        bus_addr = addr;
        bus_ack  = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; bus_strb = 4'hF; bus_wdata = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rst_gnt",   bus_gnt,   0);
        chk("rst_recv",  bus_recv,  0);
        chk("rst_err",   bus_error, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_cen",   mem_cen,   0);
        chk("rst_wstrb", mem_wstrb, 0);
        step(); step();
        reset = 1'b0;

        // single read
        drive(1'b1, 1'b0, 32'h004, 1'b1);
        @(negedge clk);
        chk("rd_gnt",  bus_gnt, 1);
        chk("rd_cen",  mem_cen, 1);
        chk("rd_addr", mem_addr, 32'h004);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rd_recv",  bus_recv, 1);
        chk("rd_rdata", bus_rdata, 32'h1000_0004);
        chk("rd_err",   bus_error, 0);
        step();

        // back-to-back reads, no bubbles
        drive(1'b1, 1'b0, 32'h000, 1'b1);
        @(negedge clk);
        chk("b2b_gnt0", bus_gnt, 1);
        chk("b2b_recv0", bus_recv, 0);
        step();
        drive(1'b1, 1'b0, 32'h004, 1'b1);
        @(negedge clk);
        chk("b2b_gnt1", bus_gnt, 1);
        chk("b2b_d0", bus_rdata, 32'h1000_0000);
        step();
        drive(1'b1, 1'b0, 32'h008, 1'b1);
        @(negedge clk);
        chk("b2b_gnt2", bus_gnt, 1);
        chk("b2b_d1", bus_rdata, 32'h1000_0004);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("b2b_recv2", bus_recv, 1);
        chk("b2b_d2", bus_rdata, 32'h1000_0008);
        step();
        @(negedge clk);
        chk("b2b_idle", bus_recv, 0);
        step();

        // backpressure: two outstanding, then drain
        drive(1'b1, 1'b0, 32'h010, 1'b0);
        @(negedge clk);
        chk("bp_gnt0", bus_gnt, 1);
        step();
        drive(1'b1, 1'b0, 32'h014, 1'b0);
        @(negedge clk);
        chk("bp_gnt1", bus_gnt, 1);
        chk("bp_cen1", mem_cen, 1);
        chk("bp_d0a", bus_rdata, 32'h1000_0010);
        step();
        drive(1'b1, 1'b0, 32'h018, 1'b0);
        @(negedge clk);
        chk("bp_gnt_full", bus_gnt, 0);
        chk("bp_cen_full", mem_cen, 0);
        chk("bp_recv", bus_recv, 1);
        chk("bp_d0b", bus_rdata, 32'h1000_0010);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("bp_d0c", bus_rdata, 32'h1000_0010);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("bp_d0d", bus_rdata, 32'h1000_0010);
        chk("bp_gnt_d0", bus_gnt, 0);
        step();
        @(negedge clk);
        chk("bp_recv1", bus_recv, 1);
        chk("bp_d1", bus_rdata, 32'h1000_0014);
        chk("bp_gnt_d1", bus_gnt, 0);
        step();
        @(negedge clk);
        chk("bp_gnt_back", bus_gnt, 1);
        chk("bp_empty", bus_recv, 0);
        step();

        // write to read-only memory
        drive(1'b1, 1'b1, 32'h020, 1'b1);
        @(negedge clk);
        chk("wr_gnt", bus_gnt, 1);
        chk("wr_cen", mem_cen, 0);
        chk("wr_wstrb", mem_wstrb, 0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("wr_recv", bus_recv, 1);
        chk("wr_err", bus_error, 1);
        chk("wr_rdata", bus_rdata, 0);
        step();

        // out-of-range read followed by a good read
        drive(1'b1, 1'b0, 32'h0000_1000, 1'b1);
        @(negedge clk);
        chk("oor_cen", mem_cen, 0);
        step();
        drive(1'b1, 1'b0, 32'h000, 1'b1);
        @(negedge clk);
        chk("oor_recv", bus_recv, 1);
        chk("oor_err", bus_error, 1);
        chk("oor_rdata", bus_rdata, 0);
        chk("oor_next_cen", mem_cen, 1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("oor_next_err", bus_error, 0);
        chk("oor_next_d", bus_rdata, 32'h1000_0000);
        step();

        // reset with two responses buffered
        drive(1'b1, 1'b0, 32'h030, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h034, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("mid_full", bus_gnt, 0);
        chk("mid_d0", bus_rdata, 32'h1000_0030);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_recv", bus_recv, 0);
        chk("mid_rst_gnt", bus_gnt, 0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("post_gnt", bus_gnt, 1);
        chk("post_recv", bus_recv, 0);
        step();
        @(negedge clk);
        chk("post_recv2", bus_recv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bus_adapter.md
Name: sram_bus_adapter

Overview:
- Sits directly upstream of the boot ROM / on-chip SRAM macros.
- Converts the CPU-side req/gnt + recv/ack memory bus into the single-cycle SRAM interface: mem_cen, mem_addr, mem_wdata, mem_wstrb, with mem_rdata one cycle later.
- Provides a 2-deep response buffer so the bus can apply backpressure via ack.
- Generates error responses for out-of-range addresses and for writes to read-only memory.

Parameters:
- ADDR_W, 12, SRAM byte-address width driven on mem_addr.
- BASE_ADDR, 32'h0000_0000, base of the decoded window. Only bits [31:ADDR_W] are compared.
- READ_ONLY, 1, when 1 every write is an error and never reaches the SRAM.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- bus_req  in  1  request valid
- bus_gnt  out  1  request accepted this cycle when bus_req && bus_gnt
- bus_wen  in  1  1 = write, 0 = read
- bus_strb  in  4  write byte strobes
- bus_addr  in  32  byte address
- bus_wdata  in  32  write data
- bus_recv  out  1  response valid
- bus_ack  in  1  response consumed when bus_recv && bus_ack
- bus_error  out  1  response is an error (qualified by bus_recv)
- bus_rdata  out  32  read data (qualified by bus_recv)
- mem_cen  out  1  SRAM access enable
- mem_addr  out  ADDR_W  SRAM byte address
- mem_wdata  out  32  SRAM write data
- mem_wstrb  out  4  SRAM write strobes
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_cen

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: hold_valid=0, s1_valid=0, bus_gnt=0, bus_recv=0, bus_error=0, bus_rdata=0, mem_cen=0, mem_wstrb=0. A reset asserted mid-transaction discards all in-flight and buffered responses with no recv.
- Grant: bus_gnt = !reset && !hold_valid.
- Accept: acc = bus_req && bus_gnt.
- Decode: hit = (bus_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]). bad = !hit || (READ_ONLY && bus_wen).
- SRAM drive (combinational, same cycle as accept):
  - mem_cen = acc && !bad.
  - mem_addr = bus_addr[ADDR_W-1:0].
  - mem_wdata = bus_wdata.
  - mem_wstrb = (acc && !bad && bus_wen && !READ_ONLY) ? bus_strb : 0.
- Stage s1 (registered):
  - s1_valid <= acc.
  - s1_err <= bad.
  - s1 data is taken from mem_rdata in the following cycle, or 0 if s1_err.
- Hold buffer: one entry of {data, err}, with hold_valid.
- Output mux:
  - bus_recv = hold_valid || s1_valid.
  - When hold_valid, present hold: bus_rdata=hold_data, bus_error=hold_err.
  - Otherwise present s1: bus_rdata = s1_err ? 0 : mem_rdata, bus_error = s1_err.
- Buffer update each cycle, with ack = bus_recv && bus_ack:
  - hold_valid && ack && s1_valid: hold <= s1 entry (mem_rdata captured). hold_valid stays 1.
  - hold_valid && ack && !s1_valid: hold_valid <= 0.
  - !hold_valid && s1_valid && !ack: hold <= s1 entry. hold_valid <= 1.
  - All other cases: hold unchanged.
- Latency:
  - Response appears the cycle after accept (1 cycle) when the buffer is empty and ack is high.
  - Throughput is 1 transaction per cycle while ack is held high.
- Capacity and ordering:
  - Maximum of 2 outstanding responses (s1 + hold).
  - Responses return strictly in request order.
  - While hold_valid, bus_gnt=0 and mem_cen=0.
- Write responses (only when READ_ONLY=0): bus_recv with bus_error=0 and bus_rdata equal to the current mem_rdata; its content is don't-care.
- Errors never assert mem_cen. The error response is otherwise timed exactly like a read.
- bus_addr[1:0] is passed through unmodified; the SRAM ignores it.

Test Plan:
- Reset then read: read at addr 0x004 with ack held 1 -> cycle 0: mem_cen=1, mem_addr=0x004. Cycle 1: bus_recv=1, bus_rdata = ROM word at 4, bus_error=0.
- Back-to-back reads: reads at 0x000, 0x004, 0x008 on consecutive cycles, ack=1 -> gnt held 1 throughout. Three recv cycles in order, no bubbles.
- Backpressure: ack=0 while issuing reads at 0x010 and 0x014 -> second accept OK, then gnt=0 and mem_cen=0. recv stays 1 with data(0x010). Then set ack=1 -> data(0x010), data(0x014) on consecutive cycles, then gnt returns 1.
- Error on write: write to 0x020 with READ_ONLY=1 -> mem_cen=0, mem_wstrb=0. Next cycle bus_recv=1, bus_error=1, bus_rdata=0.
- Error on out-of-range read: read at 0x0000_1000 with ADDR_W=12, BASE_ADDR=0 -> mem_cen=0, error response. The following read at 0x000 returns correct data.
- Reset mid-flight: two responses buffered with ack=0, then assert reset for 1 cycle -> bus_recv=0 and bus_gnt=0 during reset. After reset, bus_gnt=1 with no stale responses.
